xadc_cobs_encoder: RTL and testbench
====================================

// Module: xadc_cobs_encoder
// PURPOSE
//  Byte-stream COBS encoder placed directly downstream of the XADC packetizer, feeding the 8-bit USB FIFO.
//  Each AXIS frame (delimited by s_tlast) is COBS-encoded so that the encoded frame contains no 0x00 bytes.
//  The encoded frame is terminated by one 0x00 delimiter byte, which carries m_tlast.
//  Store-and-forward per COBS group: a group is buffered until it closes, then its code byte and data are emitted.
// PARAMETERS
//  GROUP_MAX  254  max non-zero data bytes per group; only 254 is standard COBS, other values are for sim only
// PORTS
//  clk       in   1  shared XADC-domain clock
//  rst       in   1  synchronous, active-high reset
//  s_tdata   in   8  raw packet byte
//  s_tvalid  in   1  raw byte valid
//  s_tready  out  1  encoder accepts raw byte
//  s_tlast   in   1  last byte of raw frame
//  m_tdata   out  8  encoded byte
//  m_tvalid  out  1  encoded byte valid
//  m_tready  in   1  downstream (USB FIFO) ready
//  m_tlast   out  1  asserted only on the 0x00 frame delimiter
// BEHAVIOUR
//  Reset: s_tready=0, m_tvalid=0, m_tdata=0x00, m_tlast=0, state=FILL, count=0, flags cleared; a partial frame is discarded.
//    s_tready rises the cycle after rst deasserts.
//  Storage: GROUP_MAX x 8 buffer; count (0..GROUP_MAX) is the write index; rd_idx is the read index.
//  Flags: zero_last (frame ended on a zero byte) and frame_end (delimiter due after the current group).
//  FILL: s_tready=1, m_tvalid=0. On a handshake with byte b:
//    b!=0, count<GROUP_MAX-1, !s_tlast -> store at buf[count], count++, stay in FILL.
//    b!=0, count==GROUP_MAX-1 -> store; code=0xFF; frame_end=s_tlast; no implied zero; go to SEND_CODE.
//    b!=0, s_tlast (group not full) -> store; code=count+2; frame_end=1; go to SEND_CODE.
//    b==0 -> not stored; code=count+1; zero_last=s_tlast; frame_end=0; go to SEND_CODE.
//  SEND_CODE: m_tdata=code, m_tvalid=1, s_tready=0. On m_tready: rd_idx=0.
//    If the group has data, go to SEND_DATA; otherwise go to NEXT.
//  SEND_DATA: m_tdata=buf[rd_idx]. On m_tready: rd_idx++. After the last stored byte, go to NEXT.
//  NEXT (0 cycles, decided at the final handshake):
//    zero_last -> emit an empty group: code 0x01, then the delimiter.
//    frame_end -> go to SEND_DELIM.
//    otherwise -> count=0, back to FILL.
//  SEND_DELIM: m_tdata=0x00, m_tvalid=1, m_tlast=1. On m_tready: clear flags, count=0, go to FILL.
//  Output handshake: m_tvalid/m_tdata/m_tlast are registered.
//    They are held stable while m_tvalid && !m_tready; m_tvalid never drops without a handshake.
//  Input and output never transfer in the same cycle (s_tready=0 outside FILL).
//  Latency: the code byte is valid the cycle after the group-closing input handshake.
//  Throughput: back-to-back bytes when m_tready=1.
//  Full-group boundary: a frame ending exactly on a full group emits FF+data and then 00, with no trailing 0x01.
//  Zero at group start (count=0) -> code 0x01 with no data.
//  Encoded size = raw + 1 + ceil(raw/254) bytes in the worst case; the block never emits 0x00 except the delimiter.
//  Reset mid-SEND: outputs return to reset values on the next cycle; the frame is truncated with no delimiter.
// TESTING
//  Frame {11,22,00,33 tlast}, m_tready=1 -> 03 11 22 02 33 00(tlast); 6 output bytes.
//  Frame {00 tlast} -> 01 01 00(tlast).
//  254 bytes 01..FE, tlast on FE -> FF 01..FE 00(tlast); 256 output bytes, no 0x01 before the delimiter.
//  255 bytes 01..FF, tlast on FF -> FF 01..FE 02 FF 00(tlast).
//  Frames above with m_tready toggled pseudo-randomly (50%):
//    output stream identical; m_tdata/m_tlast stable whenever m_tvalid && !m_tready.
//  rst pulsed for 1 cycle during SEND_DATA of {AA,BB,CC tlast}:
//    next cycle m_tvalid=0, s_tready=0; then frame {05 tlast} -> 02 05 00(tlast).
//  Scoreboard: reference COBS model; check that no 0x00 appears before m_tlast on any frame.

Source files
------------

// File: rtl/xadc_cobs_encoder.sv
// COBS encoder for the XADC packet byte stream. Each input frame is encoded and then closed with a 0x00 delimiter.
// Latency: the code byte is valid one cycle after the input byte that closes its group. Groups are stored and then forwarded.
// Backpressure: s_tready is high only while a group fills. Outputs stay stable while m_tvalid && !m_tready.
module xadc_cobs_encoder #(
  parameter int GROUP_MAX = 254
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] s_tdata,
  input  logic       s_tvalid,
  output logic       s_tready,
  input  logic       s_tlast,
  output logic [7:0] m_tdata,
  output logic       m_tvalid,
  input  logic       m_tready,
  output logic       m_tlast
);

  localparam int CW = $clog2(GROUP_MAX + 1);

  typedef enum logic [1:0] {
    FILL,
    SEND_CODE,
    SEND_DATA,
    SEND_DELIM
  } state_t;

  state_t          state;
  logic [7:0]      grp_buf [0:(1 << CW) - 1];
  logic [CW-1:0]   count;
  logic [CW-1:0]   rd_idx;
  logic            zero_last;
  logic            frame_end;

  logic            in_hs;
  logic            out_hs;
  logic            group_close;
  logic            group_done;
  logic [7:0]      code_val;

  assign in_hs  = s_tready && s_tvalid;
  assign out_hs = m_tvalid && m_tready;

  // Code byte for the group that closes on this input byte, and the close / finish conditions
  always_comb begin
    code_val    = 8'h00;
    group_close = 1'b0;
    group_done  = 1'b0;
    if (s_tdata == 8'h00) begin
      code_val = 8'(count) + 8'd1;
    end else if (count == CW'(GROUP_MAX - 1)) begin
      code_val = 8'(GROUP_MAX + 1);
    end else begin
      code_val = 8'(count) + 8'd2;
    end
    if (state == FILL && in_hs) begin
      group_close = (s_tdata == 8'h00) || s_tlast || (count == CW'(GROUP_MAX - 1));
    end
    if (out_hs) begin
      group_done = (state == SEND_CODE && count == '0) ||
                   (state == SEND_DATA && rd_idx == count - CW'(1));
    end
  end

  // Group storage: non-zero bytes are written at the fill index. Zero bytes are implied by the code.
  always_ff @(posedge clk) begin
    if (state == FILL && in_hs && s_tdata != 8'h00) begin
      grp_buf[count] <= s_tdata;
    end
  end

  // Encoder FSM with registered handshake outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= FILL;
      s_tready  <= 1'b0;
      m_tvalid  <= 1'b0;
      m_tdata   <= 8'h00;
      m_tlast   <= 1'b0;
      count     <= '0;
      rd_idx    <= '0;
      zero_last <= 1'b0;
      frame_end <= 1'b0;
    end else begin
      case (state)
        FILL: begin
          s_tready <= 1'b1;
          if (in_hs && s_tdata != 8'h00) begin
            count <= count + CW'(1);
          end
          if (group_close) begin
            if (s_tdata == 8'h00) begin
              zero_last <= s_tlast;
              frame_end <= 1'b0;
            end else begin
              frame_end <= s_tlast;
            end
            s_tready <= 1'b0;
            m_tvalid <= 1'b1;
            m_tdata  <= code_val;
            state    <= SEND_CODE;
          end
        end
        SEND_CODE: begin
          if (out_hs && count != '0) begin
            rd_idx  <= '0;
            m_tdata <= grp_buf[0];
            state   <= SEND_DATA;
          end
        end
        SEND_DATA: begin
          if (out_hs && !group_done) begin
            rd_idx  <= rd_idx + CW'(1);
            m_tdata <= grp_buf[rd_idx + CW'(1)];
          end
        end
        SEND_DELIM: begin
          if (out_hs) begin
            zero_last <= 1'b0;
            frame_end <= 1'b0;
            count     <= '0;
            m_tvalid  <= 1'b0;
            m_tlast   <= 1'b0;
            s_tready  <= 1'b1;
            state     <= FILL;
          end
        end
        default: state <= FILL;
      endcase

      // Last byte of a group has gone out: a trailing zero adds an empty group,
      // then the delimiter if the frame is over, otherwise start filling again.
      if (group_done) begin
        rd_idx <= '0;
        if (zero_last) begin
          zero_last <= 1'b0;
          frame_end <= 1'b1;
          count     <= '0;
          m_tdata   <= 8'h01;
          state     <= SEND_CODE;
        end else if (frame_end) begin
          m_tdata <= 8'h00;
          m_tlast <= 1'b1;
          state   <= SEND_DELIM;
        end else begin
          count    <= '0;
          m_tvalid <= 1'b0;
          s_tready <= 1'b1;
          state    <= FILL;
        end
      end
    end
  end

endmodule

// File: tb/tb_xadc_cobs_encoder.sv
// Testbench for xadc_cobs_encoder: a reference COBS model feeds a scoreboard queue.
// A monitor process drives m_tready and checks each output transfer against the queue.
// Directed frames, random frames and a mid-frame reset are applied.
module tb_xadc_cobs_encoder;

  typedef logic [7:0] byte_q_t [$];

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] s_tdata;
  logic       s_tvalid;
  logic       s_tready;
  logic       s_tlast;
  logic [7:0] m_tdata;
  logic       m_tvalid;
  logic       m_tready;
  logic       m_tlast;

  int checks = 0;
  int errors = 0;

  logic [8:0] exp_q [$];
  bit         mon_en     = 1'b0;
  bit         rand_ready = 1'b0;
  bit         gaps       = 1'b0;

  xadc_cobs_encoder #(.GROUP_MAX(254)) dut (
    .clk      (clk),
    .rst      (rst),
    .s_tdata  (s_tdata),
    .s_tvalid (s_tvalid),
    .s_tready (s_tready),
    .s_tlast  (s_tlast),
    .m_tdata  (m_tdata),
    .m_tvalid (m_tvalid),
    .m_tready (m_tready),
    .m_tlast  (m_tlast)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference COBS: groups of up to 254 non-zero bytes. Each zero closes a group.
  // A trailing zero leaves an empty final group. A frame ending on a full group adds nothing more.
  function automatic void push_expected(input byte_q_t f);
    byte_q_t grp;
    grp = {};
    foreach (f[i]) begin
      if (f[i] == 8'h00) begin
        exp_q.push_back({1'b0, 8'(grp.size() + 1)});
        foreach (grp[j]) exp_q.push_back({1'b0, grp[j]});
        grp = {};
      end else begin
        grp.push_back(f[i]);
        if (grp.size() == 254) begin
          exp_q.push_back({1'b0, 8'hFF});
          foreach (grp[j]) exp_q.push_back({1'b0, grp[j]});
          grp = {};
        end
      end
    end
    if (grp.size() > 0 || f[f.size() - 1] == 8'h00) begin
      exp_q.push_back({1'b0, 8'(grp.size() + 1)});
      foreach (grp[j]) exp_q.push_back({1'b0, grp[j]});
    end
    exp_q.push_back({1'b1, 8'h00});
  endfunction

  // Drive one byte from a negedge. The task returns at the negedge after the transfer.
  task automatic put_byte(input logic [7:0] b, input logic last);
    int budget;
    if (gaps && $urandom_range(0, 3) == 0) begin
      s_tvalid = 1'b0;
      repeat ($urandom_range(1, 3)) @(negedge clk);
    end
    s_tdata  = b;
    s_tlast  = last;
    s_tvalid = 1'b1;
    budget   = 0;
    while (!s_tready && budget < 5000) begin
      @(negedge clk);
      budget++;
    end
    if (!s_tready) check("s_tready_timeout", 32'd0, 32'd1);
    @(negedge clk);
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic send_frame(input byte_q_t f, input bit score);
    if (score) push_expected(f);
    foreach (f[i]) put_byte(f[i], i == f.size() - 1);
  endtask

  task automatic drain;
    int budget;
    budget = 0;
    while (exp_q.size() != 0 && budget < 5000) begin
      @(negedge clk);
      budget++;
    end
    check("drain_remaining", exp_q.size(), 0);
  endtask

  // Monitor: choose m_tready just after each negedge, then score the transfer that the next posedge will complete.
  initial begin
    logic [8:0] exp;
    logic [7:0] held_d;
    logic       held_l;
    bit         stalled;
    stalled  = 1'b0;
    held_d   = 8'h00;
    held_l   = 1'b0;
    m_tready = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      m_tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (mon_en) begin
        if (stalled) begin
          check("stall_valid", m_tvalid, 1'b1);
          check("stall_data", m_tdata, held_d);
          check("stall_last", m_tlast, held_l);
        end
        if (m_tvalid && m_tready) begin
          if (exp_q.size() == 0) begin
            check("unexpected_output", {m_tlast, m_tdata}, 9'h1FF);
          end else begin
            exp = exp_q.pop_front();
            check("out_byte", {m_tlast, m_tdata}, exp);
          end
          check("zero_only_on_tlast", m_tdata == 8'h00, m_tlast);
        end
        stalled = m_tvalid && !m_tready;
        held_d  = m_tdata;
        held_l  = m_tlast;
      end else begin
        stalled = 1'b0;
      end
    end
  end

  // Stimulus
  initial begin
    byte_q_t f;
    int budget;
    rst      = 1'b1;
    s_tdata  = 8'h00;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_s_tready", s_tready, 1'b0);
    check("rst_m_tvalid", m_tvalid, 1'b0);
    check("rst_m_tdata", m_tdata, 8'h00);
    check("rst_m_tlast", m_tlast, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    check("s_tready_after_rst", s_tready, 1'b1);
    mon_en = 1'b1;

    for (int pass = 0; pass < 2; pass++) begin
      rand_ready = (pass == 1);
      send_frame('{8'h11, 8'h22, 8'h00, 8'h33}, 1'b1);
      drain();
      send_frame('{8'h00}, 1'b1);
      if (pass == 0) begin
        check("code_latency_valid", m_tvalid, 1'b1);
        check("code_latency_data", m_tdata, 8'h01);
      end
      drain();
      f = {};
      for (int i = 1; i <= 254; i++) f.push_back(8'(i));
      send_frame(f, 1'b1);
      drain();
      f = {};
      for (int i = 1; i <= 255; i++) f.push_back(8'(i));
      send_frame(f, 1'b1);
      drain();
    end

    // Two full groups that end exactly on the frame, and a frame of only zeros
    f = {};
    for (int i = 0; i < 508; i++) f.push_back(8'($urandom_range(1, 255)));
    send_frame(f, 1'b1);
    f = {};
    for (int i = 0; i < 5; i++) f.push_back(8'h00);
    send_frame(f, 1'b1);
    drain();

    // Random frames with random backpressure and input gaps
    gaps = 1'b1;
    for (int n = 0; n < 10; n++) begin
      f = {};
      for (int i = 0; i < int'($urandom_range(1, 600)); i++)
        f.push_back(($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(1, 255)));
      send_frame(f, 1'b1);
    end
    drain();
    gaps       = 1'b0;
    rand_ready = 1'b0;

    // Reset while data bytes are being sent. The rest of the frame is dropped.
    mon_en = 1'b0;
    @(negedge clk);
    send_frame('{8'hAA, 8'hBB, 8'hCC}, 1'b0);
    budget = 0;
    while (!(m_tvalid && m_tdata == 8'hBB) && budget < 100) begin
      @(negedge clk);
      budget++;
    end
    check("reached_send_data", {m_tvalid, m_tdata}, {1'b1, 8'hBB});
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_m_tvalid", m_tvalid, 1'b0);
    check("midrst_s_tready", s_tready, 1'b0);
    check("midrst_m_tlast", m_tlast, 1'b0);
    @(negedge clk);
    check("midrst_s_tready_rise", s_tready, 1'b1);
    mon_en = 1'b1;
    send_frame('{8'h05}, 1'b1);
    drain();
    repeat (5) @(negedge clk);
    check("idle_m_tvalid", m_tvalid, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
